// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores to a stallable multi-cycle data memory and
// registers the writeback result. Optional macro MEM_STAGE_STORE_ACK_EN makes stores pulse wb_valid.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_ALU_Result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  output logic              ex_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err;

  logic              w_is_mem;
  logic              w_bad;
  logic              w_cpl_valid;
  logic [DATA_W-1:0] w_cpl_data;

  assign w_is_mem = ex_MemRead | ex_MemWrite;
  assign w_bad    = (ex_MemRead & ex_MemWrite) | ex_ALU_Result[0];

  // Writeback produced when the outstanding request completes; stores only ack with the macro.
  always_comb begin
    w_cpl_valid = 1'b0;
    w_cpl_data  = r_wb_data;
    if (!r_mem_wr) begin
      w_cpl_valid = 1'b1;
      w_cpl_data  = mem_rdata;
    end
`ifdef MEM_STAGE_STORE_ACK_EN
    else begin
      w_cpl_valid = 1'b1;
      w_cpl_data  = r_mem_wdata;
    end
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= ex_ALU_Result;
            end else if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_mem_addr  <= ex_ALU_Result;
              r_mem_wdata <= ex_write_data;
              r_mem_wr    <= ex_MemWrite;
              r_mem_en    <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A stalled request keeps mem_en high and is re-issued next cycle.
          if (!mem_stall) begin
            r_mem_en <= 1'b0;
            r_cnt    <= '0;
            if (mem_done) begin
              r_wb_valid <= w_cpl_valid;
              r_wb_data  <= w_cpl_data;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            r_wb_valid <= w_cpl_valid;
            r_wb_data  <= w_cpl_data;
            r_state    <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_stall  = (r_state != S_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized transactions
// scored against a transaction-level model of the memory-stage rules.
module tb_mem_stage_ctrl;

  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_ALU_Result;
  logic [DW-1:0] ex_write_data;
  logic          ex_MemRead;
  logic          ex_MemWrite;
  logic          ex_stall;
  logic          mem_en;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_stall;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: sticky error and last writeback value.
  logic          m_err;
  logic [DW-1:0] m_wb_data;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ALU_Result(ex_ALU_Result), .ex_write_data(ex_write_data),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_stall(ex_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    ex_valid = $urandom_range(0, 1);
    ex_ALU_Result = DW'($urandom);
    ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
    mem_stall = 1'b0; mem_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ex_stall, mem_en, mem_wr, wb_valid, err} !== 5'b0) begin
      n_errors++;
      $display("FAIL %s ctrl_flags: got %b expected 00000", name, {ex_stall, mem_en, mem_wr, wb_valid, err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, wb_data} !== '0) begin
      n_errors++;
      $display("FAIL %s data_regs: got %h/%h/%h expected 0", name, mem_addr, mem_wdata, wb_data);
    end
    rst = 1'b0;
    ex_valid = 1'b0;
    m_err = 1'b0;
    m_wb_data = '0;
  endtask

  // Drive one instruction and a scripted memory response, then score against the model.
  // n_stall: mem_stall cycles before acceptance; d: 0 = done with acceptance, k = done in k-th WAIT cycle.
  task automatic run_txn(input string name, input logic v, input logic rd, input logic wr,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int n_stall, input int d);
    logic          exp_wb;
    logic [DW-1:0] exp_data;
    int            exp_stall;
    int            exp_en;
    int            stall_cnt;
    int            en_cnt;
    int            req_bad;
    int            wb_early;
    bit            finished;

    exp_wb = 1'b0; exp_stall = 0; exp_en = 0;
    if (v) begin
      if (!(rd || wr)) begin
        exp_wb = 1'b1;
        m_wb_data = addr;
      end else if ((rd && wr) || addr[0]) begin
        m_err = 1'b1;
      end else begin
        exp_en = n_stall + 1;
        if (d > TO) begin
          exp_stall = n_stall + 1 + TO;
          m_err = 1'b1;
        end else begin
          exp_stall = n_stall + 1 + d;
          if (rd) begin
            exp_wb = 1'b1;
            m_wb_data = rdata;
          end
`ifdef MEM_STAGE_STORE_ACK_EN
          else begin
            exp_wb = 1'b1;
            m_wb_data = wdata;
          end
`endif
        end
      end
    end
    exp_data = m_wb_data;

    @(negedge clk);
    ex_valid = v; ex_MemRead = rd; ex_MemWrite = wr;
    ex_ALU_Result = addr; ex_write_data = wdata;
    mem_rdata = rdata; mem_stall = 1'b0;
    mem_done = 1'(($urandom_range(0, 1)));
    @(posedge clk);

    stall_cnt = 0; en_cnt = 0; req_bad = 0; wb_early = 0; finished = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge clk);
      if (!ex_stall) begin
        finished = 1'b1;
      end else begin
        stall_cnt++;
        if (mem_en) begin
          en_cnt++;
          if (mem_addr !== addr || mem_wr !== wr || mem_wdata !== wdata) req_bad++;
        end
        if (wb_valid) wb_early++;
        // Upstream garbage while stalled must never be taken.
        ex_valid = 1'b1;
        ex_MemRead = 1'(($urandom_range(0, 1)));
        ex_MemWrite = 1'(($urandom_range(0, 1)));
        ex_ALU_Result = DW'($urandom);
        ex_write_data = DW'($urandom);
        mem_stall = (c < n_stall);
        mem_done = (d == 0 && c == n_stall) || (d > 0 && c == n_stall + d);
        @(posedge clk);
      end
    end

    n_checks++;
    if (!finished) begin
      n_errors++;
      $display("FAIL %s stall_bound: ex_stall still high after 300 cycles, expected release", name);
    end
    n_checks++;
    if (stall_cnt != exp_stall) begin
      n_errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
    end
    n_checks++;
    if (en_cnt != exp_en || req_bad != 0) begin
      n_errors++;
      $display("FAIL %s mem_request: en_cycles %0d bad_fields %0d expected en_cycles %0d bad_fields 0",
               name, en_cnt, req_bad, exp_en);
    end
    n_checks++;
    if (wb_early != 0 || mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL %s stray_outputs: wb_in_stall %0d mem_en %b expected 0 and 0", name, wb_early, mem_en);
    end
    n_checks++;
    if (wb_valid !== exp_wb || wb_data !== exp_data) begin
      n_errors++;
      $display("FAIL %s writeback: got valid %b data %h expected valid %b data %h",
               name, wb_valid, wb_data, exp_wb, exp_data);
    end
    n_checks++;
    if (err !== m_err) begin
      n_errors++;
      $display("FAIL %s err: got %b expected %b", name, err, m_err);
    end

    ex_valid = 1'b0; mem_stall = 1'b0; mem_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || ex_stall !== 1'b0 || wb_data !== exp_data) begin
      n_errors++;
      $display("FAIL %s idle_after: got valid %b stall %b data %h expected 0 0 %h",
               name, wb_valid, ex_stall, wb_data, exp_data);
    end
  endtask

  task automatic test_passthrough;
    run_txn("passthrough", 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 0);
  endtask

  task automatic test_load;
    run_txn("load", 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 3);
    run_txn("load_same_cycle_done", 1'b1, 1'b1, 1'b0, 16'h0084, 16'h5555, 16'h1357, 0, 0);
  endtask

  task automatic test_store;
    run_txn("store_stalled", 1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0F0F, 2, 1);
  endtask

  task automatic test_errors;
    run_txn("misaligned", 1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0000, 0, 1);
    run_txn("err_sticky", 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 16'h0000, 0, 0);
    test_reset("reset_clears_err");
    run_txn("both_ops", 1'b1, 1'b1, 1'b1, 16'h0002, 16'h1111, 16'h0000, 0, 1);
    test_reset("reset_after_both");
  endtask

  task automatic test_timeout;
    run_txn("done_at_last_wait", 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, 1, TO);
    run_txn("timeout", 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hDEAD, 0, TO + 1);
    test_reset("reset_after_timeout");
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
    ex_ALU_Result = 16'h0020; ex_write_data = 16'h0000;
    mem_stall = 1'b0; mem_done = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      @(posedge clk);
    end
    n_checks++;
    if (ex_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_wait_stall: got %b expected 1", ex_stall);
    end
    test_reset("reset_mid_wait");
    @(negedge clk);
    mem_done = 1'b1; mem_rdata = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    mem_done = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || ex_stall !== 1'b0 || mem_en !== 1'b0 || wb_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL late_done_ignored: got valid %b stall %b en %b data %h expected 0 0 0 0000",
               wb_valid, ex_stall, mem_en, wb_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = DW'($urandom);
    @(negedge clk);
    ex_MemRead = 1'b0; ex_MemWrite = 1'b0; ex_valid = 1'b1; ex_ALU_Result = vals[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== vals[i] || ex_stall !== 1'b0) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got valid %b data %h stall %b expected 1 %h 0",
                 i, wb_valid, wb_data, ex_stall, vals[i]);
      end
      if (i < 3) ex_ALU_Result = vals[i+1];
      else ex_valid = 1'b0;
    end
    m_wb_data = vals[3];
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL back_to_back_end: got valid %b expected 0", wb_valid);
    end
  endtask

  task automatic test_random;
    logic          v, rd, wr;
    logic [DW-1:0] addr;
    int            ns, d;
    for (int i = 0; i < 60; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      rd = 1'(($urandom_range(0, 1)));
      wr = ($urandom_range(0, 5) == 0) ? ~rd : (($urandom_range(0, 7) == 0) ? rd : 1'b0);
      if ($urandom_range(0, 3) == 0) begin rd = 1'b0; wr = 1'b0; end
      addr = DW'($urandom);
      if ($urandom_range(0, 7) != 0) addr[0] = 1'b0;
      ns = $urandom_range(0, 3);
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 5);
      run_txn("random", v, rd, wr, addr, DW'($urandom), DW'($urandom), ns, d);
      if (m_err) test_reset("random_reset");
    end
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_ALU_Result = '0; ex_write_data = '0;
    ex_MemRead = 1'b0; ex_MemWrite = 1'b0; mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    m_err = 1'b0; m_wb_data = '0;
    test_reset("reset");
    test_passthrough();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
